// File: rtl/game_pkg.sv
// game_pkg: shared scheduler defaults and FSM state encoding.
package game_pkg;
  localparam int N_ENEMY_DEF = 8;
  localparam int N_SLOT_DEF = 3;
  localparam int CD_BASE_DEF = 20;
  typedef enum logic [1:0] {IDLE, SEARCH, FIRE, COOL} sched_state_t;
endpackage

// File: rtl/free_slot_pick.sv
// free_slot_pick: one-hot grant of the lowest-index free laser slot.
module free_slot_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] busy,
  output logic [N-1:0] grant,
  output logic         any_free
);
  // adding one carries through the low busy run and lands on the first free bit
  assign grant = ~busy & (busy + N'(1));
  assign any_free = ~&busy;
endmodule

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: picks a live enemy, launches it on a free laser slot,
// then holds off further grants for a randomised cooldown.
module enemy_fire_scheduler
  import game_pkg::*;
#(
  parameter int N_ENEMY = N_ENEMY_DEF,
  parameter int N_SLOT = N_SLOT_DEF,
  parameter int CD_BASE = CD_BASE_DEF
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              game_active,
  input  logic [5:0]        LFSR,
  input  logic [N_ENEMY-1:0] enemy_alive,
  input  logic [N_SLOT-1:0] slot_busy,
  output logic [N_SLOT-1:0] fire_en,
  output logic [2:0]        fire_idx,
  output logic              cooling,
  output logic              all_dead
);
  localparam int MW = $clog2(N_ENEMY + 1);
  sched_state_t state;
  logic [2:0] cand, rr_ptr;
  logic [MW-1:0] miss;
  logic [5:0] cd_cnt;
  logic [N_SLOT-1:0] grant;
  logic any_free;
  logic [7:0] alive8;
  assign alive8 = 8'(enemy_alive);
  assign cooling = |cd_cnt;
  free_slot_pick #(.N(N_SLOT)) u_pick (
    .busy(slot_busy),
    .grant(grant),
    .any_free(any_free)
  );
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      fire_en <= '0;
      fire_idx <= '0;
      rr_ptr <= '0;
      cand <= '0;
      miss <= '0;
      cd_cnt <= '0;
      all_dead <= 1'b0;
    end else begin
      all_dead <= enemy_alive == '0;
      fire_en <= '0;
      if (!game_active) begin
        state <= IDLE;
        cd_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (!all_dead && any_free) begin
            state <= SEARCH;
            cand <= rr_ptr ^ LFSR[2:0];
            miss <= '0;
          end
          SEARCH: if (alive8[cand]) begin
            state <= FIRE;
            // slot availability is sampled as FIRE is entered; a full house yields no pulse
            if (any_free) begin
              fire_idx <= cand;
              fire_en <= grant;
            end
          end else begin
            cand <= cand + 3'd1;
            miss <= miss + MW'(1);
            if (miss == MW'(N_ENEMY - 1)) state <= IDLE;
          end
          FIRE: if (|fire_en) begin
            state <= COOL;
            rr_ptr <= fire_idx + 3'd1;
            cd_cnt <= 6'(CD_BASE) + {3'b000, LFSR[5:3]};
          end else begin
            state <= IDLE;
          end
          COOL: begin
            cd_cnt <= (cd_cnt == '0) ? '0 : cd_cnt - 6'd1;
            if (cd_cnt <= 6'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler: directed vectors with hand-computed expectations.
module tb_enemy_fire_scheduler;
  logic frame_clk, Reset, game_active;
  logic [5:0] LFSR;
  logic [7:0] enemy_alive;
  logic [2:0] slot_busy, fire_en, fire_idx;
  logic cooling, all_dead;
  int n_checks = 0;
  int n_fail = 0;
  int n;
  logic seen_fire, seen_cool;

  enemy_fire_scheduler dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .game_active(game_active),
    .LFSR(LFSR),
    .enemy_alive(enemy_alive),
    .slot_busy(slot_busy),
    .fire_en(fire_en),
    .fire_idx(fire_idx),
    .cooling(cooling),
    .all_dead(all_dead)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic wait_fire(input int lim, output int cycles);
    cycles = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (fire_en != 3'b000) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic count_cool(output int cycles);
    cycles = 0;
    while (cooling && cycles < 60) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1;
    game_active = 1'b1;
    LFSR = 6'd0;
    enemy_alive = 8'hFF;
    slot_busy = 3'b000;
    @(negedge frame_clk);
    @(negedge frame_clk);
    check("rst_fire_en", fire_en, 0);
    check("rst_fire_idx", fire_idx, 0);
    check("rst_cooling", cooling, 0);
    check("rst_all_dead", all_dead, 0);
    Reset = 1'b0;
    // all alive, LFSR 0: grant on slot 0 for enemy 0, two frames out
    wait_fire(10, n);
    check("basic_latency", n, 2);
    check("basic_fire_en", fire_en, 3'b001);
    check("basic_fire_idx", fire_idx, 0);
    tick();
    check("basic_pulse_width", fire_en, 0);
    check("basic_cooling_on", cooling, 1);
    count_cool(n);
    check("basic_cool_len", n, 20);
    wait_fire(5, n);
    check("rr_latency", n, 2);
    check("rr_fire_idx", fire_idx, 1);

    // only enemy 7 alive: seven misses then grant, rr_ptr wraps to 0
    enemy_alive = 8'h80;
    do_reset();
    wait_fire(20, n);
    check("last_latency", n, 9);
    check("last_fire_idx", fire_idx, 7);
    check("last_fire_en", fire_en, 3'b001);
    enemy_alive = 8'h81;
    wait_fire(40, n);
    check("wrap_latency", n, 23);
    check("wrap_fire_idx", fire_idx, 0);

    // slots 0,1 busy, LFSR = 5<<3 | 3: slot 2, enemy 3, 25-frame cooldown
    enemy_alive = 8'hFF;
    LFSR = 6'b101_011;
    slot_busy = 3'b011;
    do_reset();
    wait_fire(10, n);
    check("slot2_latency", n, 2);
    check("slot2_fire_en", fire_en, 3'b100);
    check("slot2_fire_idx", fire_idx, 3);
    tick();
    count_cool(n);
    check("lfsr_cool_len", n, 25);
    slot_busy = 3'b000;
    tick();
    slot_busy = 3'b111;
    tick();
    check("nofree_fire_en", fire_en, 0);
    check("nofree_hold_idx", fire_idx, 3);
    slot_busy = 3'b000;
    tick();
    check("nofree_cooling", cooling, 0);
    wait_fire(5, n);
    check("nofree_retry_latency", n, 2);
    check("nofree_retry_idx", fire_idx, 7);
    check("nofree_retry_en", fire_en, 3'b001);
    tick();
    check("drop_cooling_before", cooling, 1);
    game_active = 1'b0;
    tick();
    check("drop_cooling_after", cooling, 0);
    game_active = 1'b1;
    enemy_alive = 8'h80;
    LFSR = 6'd0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("midrst_fire_en", fire_en, 0);
    check("midrst_fire_idx", fire_idx, 0);
    check("midrst_cooling", cooling, 0);
    check("midrst_all_dead", all_dead, 0);
    tick();
    check("midrst_hold_en", fire_en, 0);
    Reset = 1'b0;
    seen_fire = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_fire |= |fire_en;
    end
    check("midrst_no_early_fire", seen_fire, 0);
    wait_fire(5, n);
    check("midrst_restart_latency", n, 1);
    check("midrst_restart_idx", fire_idx, 7);

    // every slot busy: nothing ever launches
    enemy_alive = 8'hFF;
    slot_busy = 3'b111;
    do_reset();
    seen_fire = 1'b0;
    seen_cool = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_fire |= |fire_en;
      seen_cool |= cooling;
    end
    check("allbusy_fire", seen_fire, 0);
    check("allbusy_cool", seen_cool, 0);

    // no enemies alive: one empty 8-frame search, then all_dead inhibits
    enemy_alive = 8'h00;
    slot_busy = 3'b000;
    do_reset();
    tick();
    check("dead_flag", all_dead, 1);
    seen_fire = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_fire |= |fire_en;
    end
    check("dead_no_fire", seen_fire, 0);
    enemy_alive = 8'h01;
    tick();
    check("dead_flag_clear", all_dead, 0);
    wait_fire(6, n);
    check("dead_revive_latency", n, 2);
    check("dead_revive_idx", fire_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
